// File: rtl/mipi_rx_depacker_ctrl.sv
// Purpose : CSI-2 receive line controller; tracks frame/line state from decoded
//           packet headers and forwards image payload words to a raw depacker.
// Latency : 1 cycle from payload_valid_i/payload_i to depacker_valid_o/depacker_data_o;
//           line_done_o follows one cycle after the last depacker_valid_o of a line.
// Backpressure: none on payload; header_ready_o is low while a line is being
//           streamed, skipped or during the inter-line gap.
//
// Ports:
//   clk_i, reset_i           clock, asynchronous active-high reset
//   header_valid_i/ready_o   decoded header handshake, header_dt_i (6b), header_wc_i (16b)
//   payload_valid_i/_i       32-bit (4-lane) payload words, no backpressure
//   depacker_valid_o/data_o  strobe + word to the raw depacker, depacker_type_o = dt[2:0]
//   frame_start_o, frame_end_o, line_done_o   single-cycle event pulses
//   error_o                  sticky protocol error, cleared by frame start from IDLE
//   line_count_o             (only with MIPI_RX_LINE_COUNTER_EN) saturating lines-per-frame count
//
// Optional feature macro: MIPI_RX_LINE_COUNTER_EN adds line_count_o.

`timescale 1ns/1ps

module mipi_rx_depacker_ctrl #(
  parameter int unsigned MIN_GAP = 2  // inter-line idle cycles, 2..15
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        header_valid_i,
  output logic        header_ready_o,
  input  logic [5:0]  header_dt_i,
  input  logic [15:0] header_wc_i,
  input  logic        payload_valid_i,
  input  logic [31:0] payload_i,
  output logic        depacker_valid_o,
  output logic [31:0] depacker_data_o,
  output logic [2:0]  depacker_type_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic        line_done_o,
  output logic        error_o
`ifdef MIPI_RX_LINE_COUNTER_EN
  ,
  output logic [15:0] line_count_o
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FRAME = 3'd1,
    LINE  = 3'd2,
    SKIP  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [5:0] DT_RAW10 = 6'h2B;
  localparam logic [5:0] DT_RAW12 = 6'h2C;
  localparam logic [5:0] DT_LONG  = 6'h10;

  // GAP is entered on the edge of the last beat, so the FRAME cycle that
  // precedes the next header acceptance supplies the final low cycle.
  localparam logic [3:0] GAP_LOAD = 4'(MIN_GAP - 1);

  state_t      state_q;
  logic [14:0] remaining_q;
  logic [3:0]  gap_cnt_q;
  logic        last_beat_q;

  // ---------------------------------------------------------------------------
  // Header decode
  // ---------------------------------------------------------------------------
  logic        hdr_accept;
  logic        is_fs;
  logic        is_fe;
  logic        is_raw10;
  logic        is_raw12;
  logic        is_long;
  logic        wc_nonzero;
  logic        wc_misaligned;
  logic [16:0] wc_plus3;
  logic [14:0] hdr_words;

  // Ready is a pure decode of the state flop.
  assign header_ready_o = (state_q == IDLE) || (state_q == FRAME);
  assign hdr_accept     = header_valid_i && header_ready_o;

  always_comb begin
    is_fs         = (header_dt_i == DT_FS);
    is_fe         = (header_dt_i == DT_FE);
    is_raw10      = (header_dt_i == DT_RAW10);
    is_raw12      = (header_dt_i == DT_RAW12);
    is_long       = (header_dt_i >= DT_LONG);
    wc_nonzero    = (header_wc_i != 16'd0);
    // 17-bit sum so wc = 16'hFFFF rounds up to 16384 words without wrapping.
    wc_plus3      = {1'b0, header_wc_i} + 17'd3;
    hdr_words     = wc_plus3[16:2];
    // RAW10 packs 4 pixels per 5 bytes and RAW12 2 pixels per 3 bytes; a line
    // that does not end on a whole 32-bit word group of pixels is malformed.
    wc_misaligned = 1'b0;
    if (is_raw10 && ((header_wc_i % 16'd20) != 16'd0)) begin
      wc_misaligned = 1'b1;
    end
    if (is_raw12 && ((header_wc_i % 16'd12) != 16'd0)) begin
      wc_misaligned = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= IDLE;
      remaining_q      <= '0;
      gap_cnt_q        <= '0;
      last_beat_q      <= 1'b0;
      depacker_valid_o <= 1'b0;
      depacker_data_o  <= '0;
      depacker_type_o  <= '0;
      frame_start_o    <= 1'b0;
      frame_end_o      <= 1'b0;
      line_done_o      <= 1'b0;
      error_o          <= 1'b0;
    end else begin
      frame_start_o    <= 1'b0;
      frame_end_o      <= 1'b0;
      depacker_valid_o <= 1'b0;
      last_beat_q      <= 1'b0;
      // Delayed one cycle so the pulse lands just after the final data strobe.
      line_done_o      <= last_beat_q;

      case (state_q)
        IDLE: begin
          // Anything other than frame start is accepted and dropped here.
          if (hdr_accept && is_fs) begin
            state_q       <= FRAME;
            frame_start_o <= 1'b1;
            error_o       <= 1'b0;
          end
        end

        FRAME: begin
          if (hdr_accept) begin
            if (is_fe) begin
              state_q     <= IDLE;
              frame_end_o <= 1'b1;
            end else if (is_fs) begin
              // Missing frame end: restart the frame but flag it.
              frame_start_o <= 1'b1;
              error_o       <= 1'b1;
            end else if ((is_raw10 || is_raw12) && wc_nonzero) begin
              state_q         <= LINE;
              remaining_q     <= hdr_words;
              depacker_type_o <= header_dt_i[2:0];
              if (wc_misaligned) begin
                error_o <= 1'b1;
              end
            end else if (is_long && wc_nonzero) begin
              state_q     <= SKIP;
              remaining_q <= hdr_words;
            end
          end
        end

        LINE: begin
          if (payload_valid_i) begin
            depacker_valid_o <= 1'b1;
            depacker_data_o  <= payload_i;
            remaining_q      <= remaining_q - 15'd1;
            if (remaining_q == 15'd1) begin
              state_q     <= GAP;
              gap_cnt_q   <= GAP_LOAD;
              last_beat_q <= 1'b1;
            end
          end else begin
            // Lanes stalled mid-line: abandon the line; the gap that follows
            // lets the depacker flush its partial pixel group.
            error_o   <= 1'b1;
            state_q   <= GAP;
            gap_cnt_q <= GAP_LOAD;
          end
        end

        SKIP: begin
          if (payload_valid_i) begin
            remaining_q <= remaining_q - 15'd1;
            if (remaining_q == 15'd1) begin
              state_q   <= GAP;
              gap_cnt_q <= GAP_LOAD;
            end
          end
        end

        GAP: begin
          if (gap_cnt_q <= 4'd1) begin
            state_q <= FRAME;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional lines-per-frame counter
  // ---------------------------------------------------------------------------
`ifdef MIPI_RX_LINE_COUNTER_EN
  logic fs_accept;
  assign fs_accept = hdr_accept && is_fs;

  // Increments on the same edge that raises line_done_o so the count and the
  // pulse are visible together.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      line_count_o <= '0;
    end else if (fs_accept) begin
      line_count_o <= '0;
    end else if (last_beat_q && (line_count_o != 16'hFFFF)) begin
      line_count_o <= line_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mipi_rx_depacker_ctrl.sv
`timescale 1ns/1ps

module tb_mipi_rx_depacker_ctrl;

  localparam int MIN_GAP = 2;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        header_valid_i;
  logic        header_ready_o;
  logic [5:0]  header_dt_i;
  logic [15:0] header_wc_i;
  logic        payload_valid_i;
  logic [31:0] payload_i;
  logic        depacker_valid_o;
  logic [31:0] depacker_data_o;
  logic [2:0]  depacker_type_o;
  logic        frame_start_o;
  logic        frame_end_o;
  logic        line_done_o;
  logic        error_o;
`ifdef MIPI_RX_LINE_COUNTER_EN
  logic [15:0] line_count_o;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int v_cnt     = 0;  // depacker_valid_o cycles observed
  int ld_cnt    = 0;  // line_done_o pulses observed
  int fs_cnt    = 0;
  int fe_cnt    = 0;

  mipi_rx_depacker_ctrl #(.MIN_GAP(MIN_GAP)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .header_valid_i   (header_valid_i),
    .header_ready_o   (header_ready_o),
    .header_dt_i      (header_dt_i),
    .header_wc_i      (header_wc_i),
    .payload_valid_i  (payload_valid_i),
    .payload_i        (payload_i),
    .depacker_valid_o (depacker_valid_o),
    .depacker_data_o  (depacker_data_o),
    .depacker_type_o  (depacker_type_o),
    .frame_start_o    (frame_start_o),
    .frame_end_o      (frame_end_o),
    .line_done_o      (line_done_o),
    .error_o          (error_o)
`ifdef MIPI_RX_LINE_COUNTER_EN
    ,
    .line_count_o     (line_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 ns");
    $fatal(1);
  end

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
    if (depacker_valid_o) v_cnt++;
    if (line_done_o)      ld_cnt++;
    if (frame_start_o)    fs_cnt++;
    if (frame_end_o)      fe_cnt++;
  endtask

  task automatic send_hdr(input logic [5:0] dt, input logic [15:0] wc);
    header_valid_i = 1'b1;
    header_dt_i    = dt;
    header_wc_i    = wc;
    step();
    header_valid_i = 1'b0;
  endtask

  task automatic send_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      payload_valid_i = 1'b1;
      payload_i       = base + 32'(i);
      step();
    end
    payload_valid_i = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    int w;
    w = 0;
    while (!header_ready_o && w < 50) begin
      step();
      w++;
    end
    ok = header_ready_o;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_i         = 1'b1;
    header_valid_i  = 1'b0;
    header_dt_i     = '0;
    header_wc_i     = '0;
    payload_valid_i = 1'b0;
    payload_i       = '0;
    #3;
    total_cnt++;
    if ({depacker_valid_o, depacker_data_o, depacker_type_o, frame_start_o,
         frame_end_o, line_done_o, error_o} !== 40'd0)
      $display("FAIL reset_outputs: got %0h, want 0",
               {depacker_valid_o, depacker_data_o, depacker_type_o, frame_start_o,
                frame_end_o, line_done_o, error_o});
    else pass_cnt++;
    total_cnt++;
    if (header_ready_o !== 1'b1)
      $display("FAIL reset_header_ready: got %b, want 1", header_ready_o);
    else pass_cnt++;
    step();
    reset_i = 1'b0;
  endtask

  task automatic test_idle_ignore();
    v_cnt  = 0;
    fe_cnt = 0;
    send_hdr(6'h2B, 16'd40);
    send_hdr(6'h01, 16'd0);
    send_words(2, 32'h1111_0000);
    step();
    total_cnt++;
    if (header_ready_o !== 1'b1 || depacker_type_o !== 3'b000 || error_o !== 1'b0)
      $display("FAIL idle_ignore_state: got rdy=%b type=%0d err=%b, want rdy=1 type=0 err=0",
               header_ready_o, depacker_type_o, error_o);
    else pass_cnt++;
    total_cnt++;
    if (v_cnt !== 0 || fe_cnt !== 0)
      $display("FAIL idle_drop: got valid_cycles=%0d fe=%0d, want 0 0", v_cnt, fe_cnt);
    else pass_cnt++;
  endtask

  task automatic test_raw10_line();
    int bad;
    bit ok;
    send_hdr(6'h00, 16'd0);
    total_cnt++;
    if (frame_start_o !== 1'b1 || error_o !== 1'b0)
      $display("FAIL raw10_frame_start: got fs=%b err=%b, want fs=1 err=0", frame_start_o, error_o);
    else pass_cnt++;
    send_hdr(6'h2B, 16'd40);
    total_cnt++;
    if (depacker_type_o !== 3'b011 || header_ready_o !== 1'b0)
      $display("FAIL raw10_line_entry: got type=%0d rdy=%b, want type=3 rdy=0",
               depacker_type_o, header_ready_o);
    else pass_cnt++;
    v_cnt  = 0;
    ld_cnt = 0;
    fe_cnt = 0;
    bad    = 0;
    for (int i = 0; i < 10; i++) begin
      payload_valid_i = 1'b1;
      payload_i       = 32'hA000_0000 + 32'(i);
      step();
      if (depacker_valid_o !== 1'b1 || depacker_data_o !== payload_i) bad++;
    end
    payload_valid_i = 1'b0;
    total_cnt++;
    if (bad !== 0)
      $display("FAIL raw10_stream: got %0d bad beats, want 0", bad);
    else pass_cnt++;
    step();
    total_cnt++;
    if (line_done_o !== 1'b1 || depacker_valid_o !== 1'b0)
      $display("FAIL raw10_line_done: got ld=%b valid=%b, want ld=1 valid=0",
               line_done_o, depacker_valid_o);
    else pass_cnt++;
    wait_ready(ok);
    total_cnt++;
    if (!ok) $display("FAIL raw10_gap_timeout: got ready=0, want 1");
    else pass_cnt++;
    send_hdr(6'h01, 16'd0);
    total_cnt++;
    if (frame_end_o !== 1'b1 || header_ready_o !== 1'b1)
      $display("FAIL raw10_frame_end: got fe=%b rdy=%b, want 1 1", frame_end_o, header_ready_o);
    else pass_cnt++;
    total_cnt++;
    if (v_cnt !== 10 || ld_cnt !== 1 || error_o !== 1'b0)
      $display("FAIL raw10_totals: got valid=%0d ld=%0d err=%b, want 10 1 0", v_cnt, ld_cnt, error_o);
    else pass_cnt++;
    total_cnt++;
    if (depacker_data_o !== 32'hA000_0009)
      $display("FAIL raw10_data_hold: got %0h, want a0000009", depacker_data_o);
    else pass_cnt++;
  endtask

  task automatic test_raw12_two_lines();
    bit hist[$];
    bit exp_q[$];
    int w;
    int bad;
    bit ok;
    send_hdr(6'h00, 16'd0);
    send_hdr(6'h2C, 16'd24);
    total_cnt++;
    if (depacker_type_o !== 3'b100)
      $display("FAIL raw12_type: got %0d, want 4", depacker_type_o);
    else pass_cnt++;
    ld_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      payload_valid_i = 1'b1;
      payload_i       = 32'hC000_0000 + 32'(i);
      step();
      hist.push_back(depacker_valid_o);
    end
    payload_valid_i = 1'b0;
    step();
    hist.push_back(depacker_valid_o);
    w = 0;
    while (!header_ready_o && w < 50) begin
      step();
      hist.push_back(depacker_valid_o);
      w++;
    end
    total_cnt++;
    if (header_ready_o !== 1'b1) $display("FAIL raw12_gap_timeout: got ready=0, want 1");
    else pass_cnt++;
    header_valid_i = 1'b1;
    header_dt_i    = 6'h2C;
    header_wc_i    = 16'd24;
    step();
    hist.push_back(depacker_valid_o);
    header_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      payload_valid_i = 1'b1;
      payload_i       = 32'hD000_0000 + 32'(i);
      step();
      hist.push_back(depacker_valid_o);
    end
    payload_valid_i = 1'b0;
    step();
    hist.push_back(depacker_valid_o);
    // 6 high, exactly MIN_GAP low, 6 high, then low.
    for (int i = 0; i < 6; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < MIN_GAP; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < 6; i++) exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    bad = 0;
    if (hist.size() != exp_q.size()) bad = 1000;
    else for (int i = 0; i < hist.size(); i++) if (hist[i] != exp_q[i]) bad++;
    total_cnt++;
    if (bad !== 0)
      $display("FAIL raw12_burst_pattern: got len=%0d errs=%0d, want len=%0d errs=0",
               hist.size(), bad, exp_q.size());
    else pass_cnt++;
    total_cnt++;
    if (ld_cnt !== 2 || depacker_type_o !== 3'b100)
      $display("FAIL raw12_lines: got ld=%0d type=%0d, want 2 4", ld_cnt, depacker_type_o);
    else pass_cnt++;
`ifdef MIPI_RX_LINE_COUNTER_EN
    total_cnt++;
    if (line_count_o !== 16'd2)
      $display("FAIL raw12_line_count: got %0d, want 2", line_count_o);
    else pass_cnt++;
`endif
    wait_ready(ok);
    send_hdr(6'h01, 16'd0);
  endtask

  task automatic test_midline_error();
    bit ok;
    send_hdr(6'h00, 16'd0);
    send_hdr(6'h2B, 16'd40);
    v_cnt  = 0;
    ld_cnt = 0;
    send_words(4, 32'hB000_0000);
    step();
    total_cnt++;
    if (error_o !== 1'b1 || depacker_valid_o !== 1'b0)
      $display("FAIL midline_error: got err=%b valid=%b, want err=1 valid=0", error_o, depacker_valid_o);
    else pass_cnt++;
    wait_ready(ok);
    total_cnt++;
    if (!ok) $display("FAIL midline_gap_timeout: got ready=0, want 1");
    else pass_cnt++;
    total_cnt++;
    if (v_cnt !== 4 || ld_cnt !== 0)
      $display("FAIL midline_counts: got valid=%0d ld=%0d, want 4 0", v_cnt, ld_cnt);
    else pass_cnt++;
    send_hdr(6'h01, 16'd0);
    total_cnt++;
    if (frame_end_o !== 1'b1 || error_o !== 1'b1)
      $display("FAIL midline_back_to_frame: got fe=%b err=%b, want 1 1", frame_end_o, error_o);
    else pass_cnt++;
  endtask

  task automatic test_skip();
    int  k;
    bit  acc;
    bit  rdy;
    bit  ok;
    send_hdr(6'h00, 16'd0);
    total_cnt++;
    if (error_o !== 1'b0)
      $display("FAIL skip_fs_clears_error: got %b, want 0", error_o);
    else pass_cnt++;
    send_hdr(6'h12, 16'd8);
    total_cnt++;
    if (header_ready_o !== 1'b0)
      $display("FAIL skip_entry: got rdy=%b, want 0", header_ready_o);
    else pass_cnt++;
    v_cnt  = 0;
    ld_cnt = 0;
    send_words(1, 32'hE000_0000);
    step();
    send_words(1, 32'hE000_0001);
    header_valid_i = 1'b1;
    header_dt_i    = 6'h2B;
    header_wc_i    = 16'd40;
    k   = 0;
    acc = 1'b0;
    while (!acc && k < 50) begin
      rdy = header_ready_o;
      step();
      k++;
      if (rdy) acc = 1'b1;
    end
    header_valid_i = 1'b0;
    total_cnt++;
    if (!acc || k !== MIN_GAP)
      $display("FAIL skip_next_header: got accepted=%b after %0d cycles, want 1 after %0d",
               acc, k, MIN_GAP);
    else pass_cnt++;
    total_cnt++;
    if (v_cnt !== 0 || error_o !== 1'b0 || depacker_type_o !== 3'b011)
      $display("FAIL skip_silent: got valid=%0d err=%b type=%0d, want 0 0 3",
               v_cnt, error_o, depacker_type_o);
    else pass_cnt++;
    send_words(10, 32'hF000_0000);
    step();
    wait_ready(ok);
    send_hdr(6'h01, 16'd0);
    total_cnt++;
    if (ld_cnt !== 1 || v_cnt !== 10 || !ok)
      $display("FAIL skip_then_line: got ld=%0d valid=%0d ready=%b, want 1 10 1", ld_cnt, v_cnt, ok);
    else pass_cnt++;
  endtask

  task automatic test_bad_wc_reset();
    bit ok;
    send_hdr(6'h00, 16'd0);
    send_hdr(6'h2B, 16'd30);
    total_cnt++;
    if (error_o !== 1'b1)
      $display("FAIL badwc_error: got %b, want 1", error_o);
    else pass_cnt++;
    v_cnt  = 0;
    ld_cnt = 0;
    send_words(8, 32'h5000_0000);
    step();
    total_cnt++;
    if (v_cnt !== 8 || ld_cnt !== 1)
      $display("FAIL badwc_streamed: got valid=%0d ld=%0d, want 8 1", v_cnt, ld_cnt);
    else pass_cnt++;
    wait_ready(ok);
    send_hdr(6'h2B, 16'd30);
    send_words(3, 32'h6000_0000);
    #2;
    reset_i = 1'b1;
    #1;
    total_cnt++;
    if ({depacker_valid_o, depacker_data_o, depacker_type_o, frame_start_o,
         frame_end_o, line_done_o, error_o} !== 40'd0 || header_ready_o !== 1'b1)
      $display("FAIL midline_reset: got outs=%0h rdy=%b, want outs=0 rdy=1",
               {depacker_valid_o, depacker_data_o, depacker_type_o, frame_start_o,
                frame_end_o, line_done_o, error_o}, header_ready_o);
    else pass_cnt++;
`ifdef MIPI_RX_LINE_COUNTER_EN
    total_cnt++;
    if (line_count_o !== 16'd0)
      $display("FAIL reset_line_count: got %0d, want 0", line_count_o);
    else pass_cnt++;
`endif
    #1;
    reset_i = 1'b0;
    send_hdr(6'h00, 16'd0);
    total_cnt++;
    if (frame_start_o !== 1'b1 || header_ready_o !== 1'b1)
      $display("FAIL first_edge_after_reset: got fs=%b rdy=%b, want 1 1", frame_start_o, header_ready_o);
    else pass_cnt++;
  endtask

  task automatic test_fs_in_frame();
    bit ok;
    send_hdr(6'h2C, 16'd24);
    send_words(6, 32'h7000_0000);
    wait_ready(ok);
`ifdef MIPI_RX_LINE_COUNTER_EN
    total_cnt++;
    if (line_count_o !== 16'd1)
      $display("FAIL fsframe_count_before: got %0d, want 1", line_count_o);
    else pass_cnt++;
`endif
    send_hdr(6'h00, 16'd0);
    total_cnt++;
    if (error_o !== 1'b1 || frame_start_o !== 1'b1 || header_ready_o !== 1'b1 || !ok)
      $display("FAIL fs_in_frame: got err=%b fs=%b rdy=%b, want 1 1 1", error_o, frame_start_o, header_ready_o);
    else pass_cnt++;
`ifdef MIPI_RX_LINE_COUNTER_EN
    total_cnt++;
    if (line_count_o !== 16'd0)
      $display("FAIL fsframe_count_cleared: got %0d, want 0", line_count_o);
    else pass_cnt++;
`endif
    send_hdr(6'h01, 16'd0);
    total_cnt++;
    if (frame_end_o !== 1'b1 || error_o !== 1'b1)
      $display("FAIL fsframe_end_sticky: got fe=%b err=%b, want 1 1", frame_end_o, error_o);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_raw10_line();
    test_raw12_two_lines();
    test_midline_error();
    test_skip();
    test_bad_wc_reset();
    test_fs_in_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mipi_rx_depacker_ctrl.md
MIPI_RX_DEPACKER_CTRL -- requirements
Module: mipi_rx_depacker_ctrl

Interface
REQ-001 Parameter MIN_GAP, default 2: number of cycles depacker_valid_o is held low between lines (legal range 2..15).
REQ-002 clk_i  input  1  single clock for all logic.
REQ-003 reset_i  input  1  reset, asynchronous and active-high.
REQ-004 header_valid_i  input  1  decoded packet header present.
REQ-005 header_ready_o  output  1  header accepted on the same edge as header_valid_i & header_ready_o.
REQ-006 header_dt_i  input  6  CSI data type.
REQ-007 header_wc_i  input  16  long-packet word count in bytes.
REQ-008 payload_valid_i  input  1  payload word valid.
REQ-009 payload_i  input  32  4-lane payload word.
REQ-010 depacker_valid_o  output  1  data-valid strobe to the raw depacker.
REQ-011 depacker_data_o  output  32  payload word to the raw depacker.
REQ-012 depacker_type_o  output  3  header_dt_i[2:0] of the current line.
REQ-013 frame_start_o / frame_end_o / line_done_o  output  1 each  single-cycle pulses.
REQ-014 error_o  output  1  sticky protocol error.

Function
REQ-015 States: IDLE, FRAME, LINE, SKIP, GAP; header_ready_o SHALL be 1 only in IDLE and FRAME.
REQ-016 IDLE: FS (dt 0x00) -> FRAME with frame_start_o pulse next cycle and error_o cleared; all other headers are accepted and ignored.
REQ-017 FRAME: FE (dt 0x01) -> IDLE with frame_end_o pulse; FS -> stay in FRAME, error_o set, frame_start_o pulse.
REQ-018 FRAME: dt 0x2B or 0x2C with wc>0 -> LINE; remaining = (wc+3)>>2 (17-bit arithmetic, no overflow); depacker_type_o latched on the same edge.
REQ-019 FRAME: any other dt >= 0x10 with wc>0 -> SKIP with the same remaining count; wc==0 long headers and other short headers are ignored.
REQ-020 LINE: each payload_valid_i cycle -> depacker_data_o <= payload_i, depacker_valid_o <= 1 (1-cycle latency), remaining decrements.
REQ-021 LINE: the beat with remaining==1 -> GAP; line_done_o pulses in the cycle after that beat's depacker_valid_o.
REQ-022 LINE: payload_valid_i low while remaining>0 -> error_o set, depacker_valid_o 0, -> GAP, no line_done_o (a mid-line gap resets the depacker).
REQ-023 LINE entry: RAW10 wc not a multiple of 20, or RAW12 wc not a multiple of 12 -> error_o set; the line is still streamed.
REQ-024 SKIP: payload words are consumed without asserting depacker_valid_o; remaining==1 beat -> GAP; payload_valid_i low is not an error.
REQ-025 GAP: depacker_valid_o held 0 for exactly MIN_GAP cycles, then -> FRAME.
REQ-026 Payload in IDLE, FRAME and GAP SHALL be dropped; depacker_data_o holds its last value while depacker_valid_o is 0.
REQ-027 depacker_type_o SHALL change only on header acceptance into LINE, so it is stable during every depacker_valid_o low period.

Reset
REQ-028 reset_i high SHALL asynchronously force IDLE and set every output to 0, except header_ready_o, which is 1; this includes a reset asserted mid-LINE.
REQ-029 The first clock edge after reset_i deasserts SHALL be able to accept a header.

Configuration
REQ-030 Macro MIPI_RX_LINE_COUNTER_EN defined: add output line_count_o, 16 bits, counting line_done_o pulses; cleared on FS acceptance; saturates at 16'hFFFF; reset value 0.
REQ-031 Macro MIPI_RX_LINE_COUNTER_EN undefined: the line_count_o port and counter are absent; all other behaviour is identical.

Verification
REQ-032 FS, RAW10 wc=40, 10 back-to-back words, FE -> depacker_type_o=3'b011, depacker_valid_o high 10 cycles, 1 line_done_o, >=2 low cycles, frame_end_o, error_o=0.
REQ-033 FS, RAW12 wc=24, 6 words, second line wc=24 -> two 6-cycle valid bursts separated by exactly MIN_GAP low cycles, depacker_type_o=3'b100, line_count_o=2 with the macro defined.
REQ-034 RAW10 wc=40, payload_valid_i low after word 4 -> error_o=1, depacker_valid_o low, no line_done_o, return to FRAME after GAP.
REQ-035 dt 0x12 wc=8, 2 words -> depacker_valid_o stays 0, then RAW10 header accepted MIN_GAP cycles after the second word.
REQ-036 RAW10 wc=30 -> error_o=1, 8 words streamed; reset_i pulse mid-line -> IDLE, outputs 0, header_ready_o=1.
REQ-037 FS while in FRAME -> error_o=1, frame_start_o pulse, line_count_o=0.
